// File: rtl/dtc_pkg.sv
// Shared types and sizing helpers for the pipelined decision-tree classifier.
// Tree layout is a heap: internal nodes first, then leaves.
package dtc_pkg;

    // Upper bound on feature-index width held in a node entry (up to 256 features).
    localparam int FIDX_W = 8;

    typedef struct packed {
        logic              inv;
        logic [FIDX_W-1:0] fidx;
    } node_entry_t;

    function automatic int fi_w(input int n_inp);
        return (n_inp > 1) ? $clog2(n_inp) : 1;
    endfunction

    function automatic int n_nodes(input int depth);
        return (1 << depth) - 1;
    endfunction

    function automatic int n_leaves(input int depth);
        return 1 << depth;
    endfunction

    function automatic int addr_w(input int depth);
        return $clog2((1 << (depth + 1)) - 1);
    endfunction

    function automatic logic is_node_addr(input int addr, input int depth);
        return addr < n_nodes(depth);
    endfunction

    function automatic logic is_leaf_addr(input int addr, input int depth);
        return (addr >= n_nodes(depth)) && (addr < n_nodes(depth) + n_leaves(depth));
    endfunction

endpackage

// File: rtl/dtc_level_stage.sv
// One decision level: selects a feature bit, applies the node's invert flag,
// steps to the child node and registers {valid, sample, node} unless held.
module dtc_level_stage
    import dtc_pkg::*;
#(
    parameter int N_INP = 12,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold_i,
    input  logic             valid_i,
    input  logic [N_INP-1:0] data_i,
    input  logic [AW-1:0]    node_i,
    input  node_entry_t      entry_i,
    output logic             valid_o,
    output logic [N_INP-1:0] data_o,
    output logic [AW-1:0]    node_o
);

    logic             bit_sel;
    logic             decision;
    logic             valid_q, valid_d;
    logic [N_INP-1:0] data_q, data_d;
    logic [AW-1:0]    node_q, node_d;

    // NOTE: combinational blocks use blocking assignments with every output defaulted first, so no latch is inferred.
    always_comb begin
        bit_sel = 1'b0;
        for (int i = 0; i < N_INP; i++) begin
            if (entry_i.fidx == FIDX_W'(i)) begin
                bit_sel = data_i[i];
            end
        end
        decision = bit_sel ^ entry_i.inv;

        valid_d = valid_q;
        data_d  = data_q;
        node_d  = node_q;
        if (!hold_i) begin
            valid_d = valid_i;
            data_d  = data_i;
            node_d  = (node_i << 1) + AW'(1) + AW'(decision);
        end
    end

    // NOTE: only the valid bit needs reset; payload registers are qualified by it.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        data_q <= data_d;
        node_q <= node_d;
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign node_o  = node_q;

endmodule

// File: rtl/dtc_pipe_eval.sv
// Programmable pipelined decision-tree classifier: one tree level per stage,
// run-time loadable node/leaf tables, valid/ready streaming with backpressure.
module dtc_pipe_eval
    import dtc_pkg::*;
#(
    parameter  int N_INP = 12,
    parameter  int DEPTH = 4,
    parameter  int OUT_W = 1,
    localparam int FI_W  = fi_w(N_INP),
    localparam int AW    = addr_w(DEPTH),
    localparam int DW    = (FI_W + 1 > OUT_W) ? FI_W + 1 : OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_INP-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    input  logic             cfg_we,
    output logic             cfg_ready,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [DW-1:0]    cfg_data
);

    localparam int N_NODES  = n_nodes(DEPTH);
    localparam int N_LEAVES = n_leaves(DEPTH);

    node_entry_t      node_tbl_q [N_NODES];
    logic [OUT_W-1:0] leaf_tbl_q [N_LEAVES];

    // Index 0 is the pipe input; index l is the output of level l.
    logic             stg_valid [DEPTH+1];
    logic [N_INP-1:0] stg_data  [DEPTH+1];
    logic [AW-1:0]    stg_node  [DEPTH+1];

    logic             stall;
    logic             cfg_acc;
    logic             pipe_busy;
    logic [DEPTH-1:0] out_leaf;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;

    always_comb begin
        pipe_busy = 1'b0;
        for (int l = 1; l <= DEPTH; l++) begin
            pipe_busy = pipe_busy | stg_valid[l];
        end
    end

    // Config is only granted on an empty, quiet pipe so every sample sees one table.
    assign stall     = out_valid_q && !out_ready;
    assign cfg_ready = !pipe_busy && !out_valid_q && !in_valid;
    assign cfg_acc   = cfg_we && cfg_ready;
    assign in_ready  = !stall && !cfg_acc;

    assign stg_valid[0] = in_valid && in_ready;
    assign stg_data[0]  = in_data;
    assign stg_node[0]  = '0;

    for (genvar l = 1; l <= DEPTH; l++) begin : g_level
        dtc_level_stage #(
            .N_INP(N_INP),
            .AW   (AW)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .hold_i (stall),
            .valid_i(stg_valid[l-1]),
            .data_i (stg_data[l-1]),
            .node_i (stg_node[l-1]),
            .entry_i(node_tbl_q[stg_node[l-1][DEPTH-1:0]]),
            .valid_o(stg_valid[l]),
            .data_o (stg_data[l]),
            .node_o (stg_node[l])
        );
    end

    // NOTE: the tables are reset entry by entry because a defined post-reset tree is part of the contract.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NODES; i++) begin
                node_tbl_q[i] <= '0;
            end
            for (int k = 0; k < N_LEAVES; k++) begin
                leaf_tbl_q[k] <= '0;
            end
        end else if (cfg_acc) begin
            if (is_node_addr(int'(cfg_addr), DEPTH)) begin
                node_tbl_q[cfg_addr[DEPTH-1:0]] <= '{inv: cfg_data[FI_W], fidx: FIDX_W'(cfg_data[FI_W-1:0])};
            end else if (is_leaf_addr(int'(cfg_addr), DEPTH)) begin
                leaf_tbl_q[DEPTH'(cfg_addr - AW'(N_NODES))] <= cfg_data[OUT_W-1:0];
            end
        end
    end

    assign out_leaf = DEPTH'(stg_node[DEPTH] - AW'(N_NODES));

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (!stall) begin
            out_valid_d = stg_valid[DEPTH];
            if (stg_valid[DEPTH]) begin
                out_data_d = leaf_tbl_q[out_leaf];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_dtc_pipe_eval.sv
// Directed bench for dtc_pipe_eval: DEPTH=4, N_INP=12, OUT_W=1.
module tb_dtc_pipe_eval;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  out_data;
    logic        cfg_we;
    logic        cfg_ready;
    logic [4:0]  cfg_addr;
    logic [4:0]  cfg_data;

    int n_vec = 0;
    int n_err = 0;

    // Shadow of what the bench has programmed.
    logic [3:0] sh_fidx [15];
    logic       sh_inv  [15];
    logic       sh_leaf [16];

    always #5 clk = ~clk;

    dtc_pipe_eval #(.N_INP(12), .DEPTH(4), .OUT_W(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .cfg_we   (cfg_we),
        .cfg_ready(cfg_ready),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic model(input logic [11:0] x);
        int   n;
        logic b;
        n = 0;
        for (int l = 0; l < 4; l++) begin
            b = (sh_fidx[n] < 4'd12) ? x[sh_fidx[n]] : 1'b0;
            n = 2 * n + 1 + int'(b ^ sh_inv[n]);
        end
        return sh_leaf[n-15];
    endfunction

    task automatic clear_shadow();
        for (int i = 0; i < 15; i++) begin
            sh_fidx[i] = '0;
            sh_inv[i]  = 1'b0;
        end
        for (int k = 0; k < 16; k++) sh_leaf[k] = 1'b0;
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [4:0] d);
        int w;
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        #1;
        w = 0;
        while (!cfg_ready && w < 50) begin
            @(negedge clk); #1; w++;
        end
        if (!cfg_ready) begin
            n_vec++; n_err++;
            $display("FAIL cfg_write_timeout addr=%0d: cfg_ready=%b required 1", a, cfg_ready);
        end
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (a < 5'd15) begin
            sh_fidx[a] = d[3:0];
            sh_inv[a]  = d[4];
        end else if (a < 5'd31) begin
            sh_leaf[a-5'd15] = d[0];
        end
    endtask

    task automatic program_tree(input logic [4:0] root_d, input logic [4:0] l3_d, input logic [15:0] leaves);
        cfg_write(5'd0, root_d);
        cfg_write(5'd1, 5'd7);
        cfg_write(5'd2, 5'd7);
        for (int i = 3; i <= 6; i++) cfg_write(5'(i), 5'd3);
        for (int i = 7; i <= 14; i++) cfg_write(5'(i), l3_d);
        for (int k = 0; k < 16; k++) cfg_write(5'(15 + k), {4'b0, leaves[k]});
    endtask

    // Single sample: checks the 4-cycle latency and the class value.
    task automatic run_one(input logic [11:0] d, input logic exp, input string name);
        int cyc;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            cyc++;
        end
        n_vec++;
        if (cyc !== 4) begin
            n_err++;
            $display("FAIL %s_latency: got %0d cycles, required 4", name, cyc);
        end
        n_vec++;
        if (out_data !== exp) begin
            n_err++;
            $display("FAIL %s_data: got %b, required %b", name, out_data, exp);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_shadow();
        @(negedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        n_vec++;
        if (out_data !== 1'b0) begin n_err++; $display("FAIL reset_out_data: got %b, required 0", out_data); end
        n_vec++;
        if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready: got %b, required 1", cfg_ready); end
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_basic();
        program_tree(5'h02, 5'h0A, 16'hAAAA);
        run_one(12'h400, 1'b1, "basic_400");
        run_one(12'h000, 1'b0, "basic_000");
    endtask

    task automatic test_invert();
        for (int i = 7; i <= 14; i++) cfg_write(5'(i), 5'h1A);
        run_one(12'h400, 1'b0, "inv_400");
        run_one(12'h000, 1'b1, "inv_000");
    endtask

    task automatic test_stream();
        logic [11:0] s [16];
        logic        e [16];
        int          got, last, gaps;
        program_tree(5'h02, 5'h0A, 16'h6C93);
        for (int i = 0; i < 16; i++) begin
            s[i] = 12'(i * 419) ^ 12'(i << 7);
            e[i] = model(s[i]);
        end
        got = 0; last = -1; gaps = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    @(negedge clk);
                    in_valid = 1'b1; in_data = s[i];
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 40 && got < 16; c++) begin
                    @(negedge clk); #1;
                    if (out_valid) begin
                        n_vec++;
                        if (out_data !== e[got]) begin
                            n_err++;
                            $display("FAIL stream_data[%0d]: got %b, required %b", got, out_data, e[got]);
                        end
                        if (last >= 0 && c != last + 1) gaps++;
                        last = c;
                        got++;
                    end
                end
            end
        join
        n_vec++;
        if (got !== 16) begin n_err++; $display("FAIL stream_count: got %0d results, required 16", got); end
        n_vec++;
        if (gaps !== 0) begin n_err++; $display("FAIL stream_bubbles: got %0d gaps, required 0", gaps); end
    endtask

    task automatic test_stall();
        logic [11:0] s [10];
        logic        e [10];
        int          sent, got, stalls;
        for (int i = 0; i < 10; i++) begin
            s[i] = 12'(i * 1237 + 91);
            e[i] = model(s[i]);
        end
        sent = 0; got = 0; stalls = 0;
        for (int c = 0; c < 80 && got < 10; c++) begin
            @(negedge clk);
            out_ready = !(c >= 6 && c < 11);
            in_valid  = (sent < 10);
            if (sent < 10) in_data = s[sent];
            #1;
            if (out_valid && out_ready) begin
                n_vec++;
                if (out_data !== e[got]) begin
                    n_err++;
                    $display("FAIL stall_data[%0d]: got %b, required %b", got, out_data, e[got]);
                end
                got++;
            end else if (out_valid && !out_ready) begin
                stalls++;
                n_vec++;
                if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready c=%0d: got %b, required 0", c, in_ready); end
                n_vec++;
                if (out_data !== e[got]) begin n_err++; $display("FAIL stall_hold c=%0d: got %b, required %b", c, out_data, e[got]); end
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_vec++;
        if (got !== 10) begin n_err++; $display("FAIL stall_count: got %0d results, required 10", got); end
        n_vec++;
        if (stalls !== 5) begin n_err++; $display("FAIL stall_cycles: got %0d, required 5", stalls); end
    endtask

    task automatic test_root_oob();
        program_tree(5'h0D, 5'h0A, 16'h0001);
        run_one(12'h000, 1'b1, "oob_000");
        run_one(12'h004, 1'b1, "oob_004");
        run_one(12'h800, 1'b1, "oob_800");
        run_one(12'h400, 1'b0, "oob_400");
        run_one(12'hFFF, 1'b0, "oob_FFF");
    endtask

    task automatic test_cfg_busy();
        int results, first;
        program_tree(5'h02, 5'h0A, 16'hAAAA);
        results = 0; first = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            in_valid = (c < 3); in_data = 12'h400;
            cfg_we = 1'b1; cfg_addr = 5'd16; cfg_data = 5'd0;
            #1;
            if (out_valid) begin
                results++;
                n_vec++;
                if (out_data !== 1'b1) begin n_err++; $display("FAIL busy_old_table: got %b, required 1", out_data); end
            end
            if (cfg_ready) begin
                first = c;
                break;
            end
        end
        @(posedge clk); #1;
        cfg_we = 1'b0;
        sh_leaf[1] = 1'b0;
        n_vec++;
        if (first !== 8) begin n_err++; $display("FAIL busy_cfg_ready_cycle: got %0d, required 8", first); end
        n_vec++;
        if (results !== 3) begin n_err++; $display("FAIL busy_results: got %0d, required 3", results); end
        run_one(12'h400, 1'b0, "busy_write_applied");
    endtask

    task automatic test_reset_mid();
        int seen;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 12'h400;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_shadow();
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b, required 0", out_valid); end
        n_vec++;
        if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL midrst_cfg_ready: got %b, required 1", cfg_ready); end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            if (out_valid) seen++;
        end
        n_vec++;
        if (seen !== 0) begin n_err++; $display("FAIL midrst_partial: got %0d results, required 0", seen); end
        run_one(12'hFFF, 1'b0, "midrst_leaf_zero");
        cfg_write(5'd30, 5'd1);
        run_one(12'h001, 1'b1, "midrst_node_zero_right");
        run_one(12'hFFE, 1'b0, "midrst_node_zero_left");
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        test_reset();
        run_one(12'hFFF, 1'b0, "empty_tables");
        test_basic();
        test_invert();
        test_stream();
        test_stall();
        test_root_oob();
        test_cfg_busy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
